layer_index_sequencer: RTL and testbench
========================================

// Module: layer_index_sequencer
// PURPOSE
// - Two-level nested index counter for fully-connected layers: inner index walks inputs
//   (pixels/activations), outer index walks neurons; emits a flat weight-ROM address.
// - Adds start/busy/done handshake, stall (en), abort and last-flags over the single-level counter.
// - Sits between layer control FSM and weight/input ROM address ports + MAC accumulator.
// PARAMETERS
// - IN_COUNT   784   inner beats per neuron (>=1)
// - OUT_COUNT  10    neurons per layer (>=1)
// - IN_W       10    width of in_idx; 2**IN_W >= IN_COUNT
// - OUT_W      4     width of out_idx; 2**OUT_W >= OUT_COUNT
// - ADDR_W     13    width of addr; 2**ADDR_W >= IN_COUNT*OUT_COUNT
// PORTS
// - clk        in   1       clock, rising edge
// - rst        in   1       reset, asynchronous, active-low
// - start      in   1       begin a layer pass; sampled only in IDLE
// - en         in   1       advance one beat; low = stall (hold all state)
// - abort      in   1       synchronous cancel of a running pass
// - busy       out  1       high while in RUN
// - valid      out  1       in_idx/out_idx/addr are a live beat (== busy)
// - in_idx     out  IN_W    inner index 0..IN_COUNT-1
// - out_idx    out  OUT_W   outer index 0..OUT_COUNT-1
// - addr       out  ADDR_W  flat address = out_idx*IN_COUNT + in_idx
// - last_in    out  1       valid & in_idx==IN_COUNT-1 (neuron's final beat; MAC flush)
// - last_out   out  1       valid & out_idx==OUT_COUNT-1
// - done       out  1       one-cycle pulse after final beat consumed
// BEHAVIOUR
// - Reset: state=IDLE; busy, valid, in_idx, out_idx, addr, done = 0.
// - FSM: IDLE --start & !abort--> RUN; RUN --abort--> IDLE; RUN --en & last_in & last_out--> IDLE.
// - Start latency 1: cycle after start sampled: busy=valid=1, in_idx=out_idx=addr=0.
// - Beat consumed on every RUN cycle with en=1. On consume:
//   - in_idx<IN_COUNT-1: in_idx+1; else in_idx->0 and out_idx+1.
//   - addr+1 (incremental; no multiplier). Final beat: all indices -> 0.
// - en=0 in RUN: every output holds; no beat lost or repeated.
// - Final beat (en & last_in & last_out): next cycle IDLE, done=1 one cycle, valid=0, idx/addr=0.
// - done is registered; low in all other cycles. Never asserted on abort.
// - abort: priority over en; next cycle IDLE, idx/addr=0, no done. Ignored in IDLE.
// - start while busy: ignored. start & abort same cycle in IDLE: stay IDLE.
// - start in done cycle (state IDLE): accepted; new pass runs back-to-back.
// - IN_COUNT=1: last_in high every beat; out_idx steps each beat.
// - last_in/last_out combinational from registered state; forced 0 when !valid.
// - rst mid-pass: immediate return to reset values; no done.
// CONFIGURATION
// - SEQ_STALL_CNT_EN defined: extra output stall_cnt [15:0]; counts RUN cycles with en=0,
//   cleared to 0 on accepted start, saturates at 16'hFFFF, held in IDLE, 0 on reset.
// - Not defined: port and counter absent; all other behaviour identical.
// TESTING
// - Defaults, start then en=1 constant -> addr 0..7839 once each; out_idx steps at in_idx 783->0;
//   last_in on 10 beats; done pulse exactly 1 cycle, cycle after addr=7839.
// - en toggled pseudo-randomly -> exactly 7840 consumed beats, addr strictly +1 per beat, hold on en=0.
// - start pulsed at addr=50 -> ignored; abort at addr=100 -> IDLE next cycle, no done;
//   restart -> addr 0.
// - rst low at addr=3000 -> all outputs 0 same cycle; after release, IDLE until start.
// - IN_COUNT=1, OUT_COUNT=3 -> addr 0,1,2; last_in high all 3 beats; last_out on addr=2; done after 3 beats.
// - SEQ_STALL_CNT_EN: 5 stall cycles mid-pass -> stall_cnt=5 at done; next start -> 0.

Source files
------------

// File: rtl/layer_index_sequencer_if.sv
// Bundle of the handshake and address signals between the layer control FSM
// (master) and the layer index sequencer (slave).
interface layer_index_sequencer_if #(
    parameter int IN_W   = 10,
    parameter int OUT_W  = 4,
    parameter int ADDR_W = 13
);
    logic              start;
    logic              en;
    logic              abort;
    logic              busy;
    logic              valid;
    logic [IN_W-1:0]   in_idx;
    logic [OUT_W-1:0]  out_idx;
    logic [ADDR_W-1:0] addr;
    logic              last_in;
    logic              last_out;
    logic              done;

    modport master (
        output start, en, abort,
        input  busy, valid, in_idx, out_idx, addr, last_in, last_out, done
    );

    modport slave (
        input  start, en, abort,
        output busy, valid, in_idx, out_idx, addr, last_in, last_out, done
    );
endinterface

// File: rtl/layer_index_sequencer.sv
// Two-level nested index sequencer for fully-connected layers.
// The inner index walks inputs and the outer index walks neurons. A flat
// weight-ROM address is kept incrementally, so no multiplier is needed.
// Optional feature macro: SEQ_STALL_CNT_EN adds stall_cnt_o, a saturating
// count of RUN cycles spent with en low.
module layer_index_sequencer #(
    parameter int IN_COUNT  = 784,
    parameter int OUT_COUNT = 10,
    parameter int IN_W      = 10,
    parameter int OUT_W     = 4,
    parameter int ADDR_W    = 13
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef SEQ_STALL_CNT_EN
    output logic [15:0]                 stall_cnt_o,
`endif
    layer_index_sequencer_if.slave      bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   in_idx_q, in_idx_d;
    logic [OUT_W-1:0]  out_idx_q, out_idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              run_s;
    logic              last_in_s;
    logic              last_out_s;

    // Beat flags derive from registered state and are gated by valid.
    always_comb begin
        run_s      = (state_q == ST_RUN);
        last_in_s  = run_s & (in_idx_q == IN_W'(IN_COUNT - 1));
        last_out_s = run_s & (out_idx_q == OUT_W'(OUT_COUNT - 1));
    end

    // Next-state logic: start/abort handshake and beat advance on en.
    always_comb begin
        state_d   = state_q;
        in_idx_d  = in_idx_q;
        out_idx_d = out_idx_q;
        addr_d    = addr_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    // Cancel takes priority over a beat and never signals done.
                    state_d   = ST_IDLE;
                    in_idx_d  = {IN_W{1'b0}};
                    out_idx_d = {OUT_W{1'b0}};
                    addr_d    = {ADDR_W{1'b0}};
                end else if (bus.en) begin
                    if (last_in_s && last_out_s) begin
                        state_d   = ST_IDLE;
                        in_idx_d  = {IN_W{1'b0}};
                        out_idx_d = {OUT_W{1'b0}};
                        addr_d    = {ADDR_W{1'b0}};
                        done_d    = 1'b1;
                    end else if (last_in_s) begin
                        in_idx_d  = {IN_W{1'b0}};
                        out_idx_d = out_idx_q + OUT_W'(1);
                        addr_d    = addr_q + ADDR_W'(1);
                    end else begin
                        in_idx_d  = in_idx_q + IN_W'(1);
                        addr_d    = addr_q + ADDR_W'(1);
                    end
                end else begin
                    // Stall: hold every index so no beat is lost or repeated.
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                in_idx_d  = {IN_W{1'b0}};
                out_idx_d = {OUT_W{1'b0}};
                addr_d    = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State and index registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            in_idx_q  <= {IN_W{1'b0}};
            out_idx_q <= {OUT_W{1'b0}};
            addr_q    <= {ADDR_W{1'b0}};
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_idx_q  <= in_idx_d;
            out_idx_q <= out_idx_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
        end
    end

`ifdef SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Stall counter: cleared on an accepted start, saturating while RUN sees en low.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == ST_IDLE) begin
            if (bus.start && !bus.abort) begin
                stall_cnt_d = 16'h0000;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end else if (!bus.en && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'h0001;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    assign bus.busy     = run_s;
    assign bus.valid    = run_s;
    assign bus.in_idx   = in_idx_q;
    assign bus.out_idx  = out_idx_q;
    assign bus.addr     = addr_q;
    assign bus.last_in  = last_in_s;
    assign bus.last_out = last_out_s;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_layer_index_sequencer.sv
// Directed testbench for layer_index_sequencer: a default-sized 784x10 instance
// and a 1x3 instance share one clock and reset. Build with SEQ_STALL_CNT_EN
// defined to also check the stall counter.
module tb_layer_index_sequencer;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    layer_index_sequencer_if #(.IN_W(10), .OUT_W(4), .ADDR_W(13)) m ();
    layer_index_sequencer_if #(.IN_W(1),  .OUT_W(2), .ADDR_W(2))  s ();

`ifdef SEQ_STALL_CNT_EN
    logic [15:0] m_stall;
    logic [15:0] s_stall;
`endif

    layer_index_sequencer #(
        .IN_COUNT(784), .OUT_COUNT(10), .IN_W(10), .OUT_W(4), .ADDR_W(13)
    ) dut_main (
        .clk         (clk),
        .rst         (rst),
`ifdef SEQ_STALL_CNT_EN
        .stall_cnt_o (m_stall),
`endif
        .bus         (m.slave)
    );

    layer_index_sequencer #(
        .IN_COUNT(1), .OUT_COUNT(3), .IN_W(1), .OUT_W(2), .ADDR_W(2)
    ) dut_small (
        .clk         (clk),
        .rst         (rst),
`ifdef SEQ_STALL_CNT_EN
        .stall_cnt_o (s_stall),
`endif
        .bus         (s.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lin_cnt;
        int exp_a;
        int consumed;
        bit done_seen;
        bit en_v;

        tests = 0;
        fails = 0;
        rst = 1'b0;
        m.start = 1'b0; m.en = 1'b0; m.abort = 1'b0;
        s.start = 1'b0; s.en = 1'b0; s.abort = 1'b0;
        #12;
        check("rst_busy",  32'(m.busy),    32'd0);
        check("rst_valid", 32'(m.valid),   32'd0);
        check("rst_addr",  32'(m.addr),    32'd0);
        check("rst_in",    32'(m.in_idx),  32'd0);
        check("rst_out",   32'(m.out_idx), 32'd0);
        check("rst_done",  32'(m.done),    32'd0);
        rst = 1'b1;
        step();
        step();
        check("idle_busy", 32'(m.busy), 32'd0);

        // start together with abort in IDLE: must stay idle
        m.start = 1'b1; m.abort = 1'b1;
        step();
        check("start_abort_idle", 32'(m.busy), 32'd0);
        m.abort = 1'b0;

        // pass 1: en held high, walk every beat
        m.en = 1'b1;
        step();
        m.start = 1'b0;
        check("p1_start_busy", 32'(m.busy), 32'd1);
        lin_cnt = 0;
        for (int b = 0; b < 7840; b++) begin
            check("p1_addr",     32'(m.addr),     32'(b));
            check("p1_in",       32'(m.in_idx),   32'(b % 784));
            check("p1_out",      32'(m.out_idx),  32'(b / 784));
            check("p1_last_in",  32'(m.last_in),  32'((b % 784) == 783));
            check("p1_last_out", 32'(m.last_out), 32'((b / 784) == 9));
            check("p1_done_low", 32'(m.done),     32'd0);
            lin_cnt += int'(m.last_in);
            step();
        end
        check("p1_done",      32'(m.done),    32'd1);
        check("p1_end_busy",  32'(m.busy),    32'd0);
        check("p1_end_valid", 32'(m.valid),   32'd0);
        check("p1_end_addr",  32'(m.addr),    32'd0);
        check("p1_end_out",   32'(m.out_idx), 32'd0);
        check("p1_end_lin",   32'(m.last_in), 32'd0);
        check("p1_lin_count", 32'(lin_cnt),   32'd10);

        // start during the done cycle: back-to-back pass 2 with random stalls
        m.start = 1'b1; m.en = 1'b0;
        step();
        m.start = 1'b0;
        check("p2_busy",      32'(m.busy), 32'd1);
        check("p2_addr0",     32'(m.addr), 32'd0);
        check("p2_done_once", 32'(m.done), 32'd0);
        exp_a = 0; consumed = 0; done_seen = 1'b0;
        for (int c = 0; c < 40000 && !done_seen; c++) begin
            en_v = 1'($urandom_range(0, 1));
            m.en = en_v;
            step();
            if (en_v) begin
                consumed++;
                if (exp_a == 7839) begin
                    done_seen = 1'b1;
                    check("p2_done", 32'(m.done), 32'd1);
                    check("p2_end_busy", 32'(m.busy), 32'd0);
                end else begin
                    exp_a++;
                    check("p2_addr_step", 32'(m.addr),   32'(exp_a));
                    check("p2_in_step",   32'(m.in_idx), 32'(exp_a % 784));
                end
            end else begin
                check("p2_addr_hold", 32'(m.addr),  32'(exp_a));
                check("p2_hold_busy", 32'(m.busy),  32'd1);
                check("p2_hold_done", 32'(m.done),  32'd0);
            end
        end
        check("p2_done_seen", 32'(done_seen), 32'd1);
        check("p2_consumed",  32'(consumed),  32'd7840);
        m.en = 1'b0;
        step();
        check("p2_done_pulse", 32'(m.done), 32'd0);

        // pass 3: start at addr 50 ignored, abort at addr 100
        m.start = 1'b1; m.en = 1'b1;
        step();
        for (int b = 0; b < 100; b++) begin
            m.start = (b == 50);
            step();
            check("p3_addr", 32'(m.addr), 32'(b + 1));
        end
        m.start = 1'b0;
        m.abort = 1'b1;
        step();
        m.abort = 1'b0;
        check("abort_busy", 32'(m.busy),    32'd0);
        check("abort_done", 32'(m.done),    32'd0);
        check("abort_addr", 32'(m.addr),    32'd0);
        check("abort_out",  32'(m.out_idx), 32'd0);
        step();
        check("abort_done_next", 32'(m.done), 32'd0);
        check("abort_idle_next", 32'(m.busy), 32'd0);

        // restart, then reset mid-pass at addr 3000
        m.start = 1'b1;
        step();
        m.start = 1'b0;
        check("restart_addr", 32'(m.addr), 32'd0);
        check("restart_busy", 32'(m.busy), 32'd1);
        repeat (3000) step();
        check("pre_rst_addr", 32'(m.addr),   32'd3000);
        check("pre_rst_in",   32'(m.in_idx), 32'd3000 % 32'd784);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(m.busy),    32'd0);
        check("mid_rst_addr", 32'(m.addr),    32'd0);
        check("mid_rst_in",   32'(m.in_idx),  32'd0);
        check("mid_rst_out",  32'(m.out_idx), 32'd0);
        check("mid_rst_done", 32'(m.done),    32'd0);
        #2 rst = 1'b1;
        step();
        step();
        check("post_rst_idle", 32'(m.busy), 32'd0);
        check("post_rst_done", 32'(m.done), 32'd0);
        m.en = 1'b0;

        // small instance: IN_COUNT=1, OUT_COUNT=3 with 5 stall cycles
        s.start = 1'b1; s.en = 1'b1;
        step();
        s.start = 1'b0;
        check("s_addr0",    32'(s.addr),     32'd0);
        check("s_lin0",     32'(s.last_in),  32'd1);
        check("s_lout0",    32'(s.last_out), 32'd0);
        step();
        check("s_addr1",    32'(s.addr),     32'd1);
        check("s_out1",     32'(s.out_idx),  32'd1);
        check("s_lin1",     32'(s.last_in),  32'd1);
        check("s_lout1",    32'(s.last_out), 32'd0);
        s.en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("s_stall_hold", 32'(s.addr), 32'd1);
            check("s_stall_busy", 32'(s.busy), 32'd1);
        end
        s.en = 1'b1;
        step();
        check("s_addr2",    32'(s.addr),     32'd2);
        check("s_lin2",     32'(s.last_in),  32'd1);
        check("s_lout2",    32'(s.last_out), 32'd1);
        check("s_done_low", 32'(s.done),     32'd0);
        step();
        check("s_done",     32'(s.done),     32'd1);
        check("s_end_busy", 32'(s.busy),     32'd0);
        check("s_end_lin",  32'(s.last_in),  32'd0);
`ifdef SEQ_STALL_CNT_EN
        check("s_stall_cnt", 32'(s_stall), 32'd5);
`endif
        s.start = 1'b1; s.en = 1'b0;
        step();
        s.start = 1'b0;
        check("s_restart_busy", 32'(s.busy), 32'd1);
`ifdef SEQ_STALL_CNT_EN
        check("s_stall_clr", 32'(s_stall), 32'd0);
`endif
        s.abort = 1'b1;
        step();
        s.abort = 1'b0;
        check("s_abort_busy", 32'(s.busy), 32'd0);
        check("s_abort_done", 32'(s.done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
